// File: rtl/ixc_assign_pkg.sv
// rtl/ixc_assign_pkg.sv - shared constants, force-state type and parameter check for ixc_assign_pipe
package ixc_assign_pkg;

    localparam int MAX_STAGES = 8;

    typedef enum logic {
        FREE   = 1'b0,
        FORCED = 1'b1
    } force_state_e;

    // STAGES must lie in 0..MAX_STAGES.
    function automatic bit stages_legal(input int s);
        return (s >= 0) && (s <= MAX_STAGES);
    endfunction

endpackage

// File: rtl/ixc_assign_pipe_if.sv
// rtl/ixc_assign_pipe_if.sv - source/force/destination signal bundle for ixc_assign_pipe
interface ixc_assign_pipe_if #(
    parameter int WIDTH = 6
);
    logic             en;
    logic [WIDTH-1:0] R;
    logic             force_req;
    logic [WIDTH-1:0] force_val;
    logic [WIDTH-1:0] force_mask;
    logic             release_req;
    logic [WIDTH-1:0] L;
    logic             valid;
    logic             forced;

    modport master (
        output en, R, force_req, force_val, force_mask, release_req,
        input  L, valid, forced
    );

    modport slave (
        input  en, R, force_req, force_val, force_mask, release_req,
        output L, valid, forced
    );
endinterface

// File: rtl/ixc_assign_stage.sv
// rtl/ixc_assign_stage.sv - one enabled pipeline register with synchronous clear
module ixc_assign_stage #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d on enabled edges; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ixc_assign_pipe.sv
// rtl/ixc_assign_pipe.sv - delayed assignment L <= R with per-bit force/release overlay
module ixc_assign_pipe
    import ixc_assign_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int STAGES   = 2,
    parameter int FORCE_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    ixc_assign_pipe_if.slave  bus
);

    localparam int CW = $clog2(MAX_STAGES + 1);

    if (!stages_legal(STAGES)) begin : g_bad_stages
        $error("ixc_assign_pipe: STAGES out of range 0..8");
    end

    // taps[0] is the live source, taps[k] the output of stage k-1.
    logic [STAGES:0][WIDTH-1:0] taps;
    logic [WIDTH-1:0]           pipe_out;
    logic [WIDTH-1:0]           mask_eff;
    logic [WIDTH-1:0]           val_eff;
    logic                       force_on;

    assign taps[0] = bus.R;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        ixc_assign_stage #(.WIDTH(WIDTH)) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (bus.en),
            .d   (taps[k]),
            .q   (taps[k+1])
        );
    end

    assign pipe_out = taps[STAGES];

    if (STAGES == 0) begin : g_no_fill
        assign bus.valid = 1'b1;
    end else begin : g_fill
        logic [CW-1:0] fill_q;

        // Count enabled edges since reset, saturating once the pipe is full.
        always_ff @(posedge clk) begin
            if (rst) begin
                fill_q <= '0;
            end else if (bus.en && (fill_q != CW'(STAGES))) begin
                fill_q <= fill_q + CW'(1);
            end
        end

        assign bus.valid = (fill_q == CW'(STAGES));
    end

    if (FORCE_EN != 0) begin : g_force
        force_state_e     state_q;
        force_state_e     state_d;
        logic [WIDTH-1:0] mask_q;
        logic [WIDTH-1:0] mask_d;
        logic [WIDTH-1:0] val_q;
        logic [WIDTH-1:0] val_d;
        logic [WIDTH-1:0] base_mask;

        // Force state, mask and value registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= FREE;
                mask_q  <= '0;
                val_q   <= '0;
            end else begin
                state_q <= state_d;
                mask_q  <= mask_d;
                val_q   <= val_d;
            end
        end

        // Release is applied before a same-cycle force, so the new mask is
        // exactly force_mask in that case; an all-zero force mask is a no-op.
        always_comb begin
            base_mask = bus.release_req ? '0 : mask_q;
            mask_d    = base_mask;
            val_d     = val_q;
            if (bus.force_req && (bus.force_mask != '0)) begin
                mask_d = base_mask | bus.force_mask;
                if (base_mask == '0) begin
                    val_d = bus.force_val;
                end else begin
                    val_d = (val_q & ~bus.force_mask) | (bus.force_val & bus.force_mask);
                end
            end
            state_d = (mask_d != '0) ? FORCED : FREE;
        end

        assign mask_eff = mask_q;
        assign val_eff  = val_q;
        assign force_on = (state_q == FORCED);
    end else begin : g_no_force
        assign mask_eff = '0;
        assign val_eff  = '0;
        assign force_on = 1'b0;
    end

    assign bus.L      = (val_eff & mask_eff) | (pipe_out & ~mask_eff);
    assign bus.forced = force_on;

endmodule

// File: tb/tb_ixc_assign_pipe.sv
// tb/tb_ixc_assign_pipe.sv - self-checking bench for ixc_assign_pipe
module tb_ixc_assign_pipe;

    localparam int W  = 6;
    localparam int ST = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ixc_assign_pipe_if #(.WIDTH(W)) bus  ();
    ixc_assign_pipe_if #(.WIDTH(W)) bus0 ();

    ixc_assign_pipe #(.WIDTH(W), .STAGES(ST), .FORCE_EN(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    ixc_assign_pipe #(.WIDTH(W), .STAGES(0), .FORCE_EN(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    // Reference model: accepted-sample history plus force mask/value.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_mask = '0;
    logic [W-1:0] m_val  = '0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_pipe();
        if (hist.size() >= ST) return hist[ST-1];
        return '0;
    endfunction

    function automatic logic [W-1:0] exp_l();
        return (m_val & m_mask) | (exp_pipe() & ~m_mask);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            m_mask = '0;
            m_val  = '0;
        end else begin
            if (bus.en) begin
                hist.push_front(bus.R);
                if (hist.size() > 8) void'(hist.pop_back());
            end
            if (bus.release_req) m_mask = '0;
            if (bus.force_req && bus.force_mask != 0) begin
                if (m_mask == 0) m_val = bus.force_val;
                else             m_val = (m_val & ~bus.force_mask) | (bus.force_val & bus.force_mask);
                m_mask = m_mask | bus.force_mask;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_L",      8'(bus.L),      8'(exp_l()));
            check("model_valid",  8'(bus.valid),  8'(hist.size() >= ST));
            check("model_forced", 8'(bus.forced), 8'(m_mask != 0));
        end
    end

    task automatic idle();
        rst             = 1'b0;
        bus.en          = 1'b0;
        bus.R           = '0;
        bus.force_req   = 1'b0;
        bus.force_val   = '0;
        bus.force_mask  = '0;
        bus.release_req = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
    endtask

    task automatic force_it(input logic [W-1:0] m, input logic [W-1:0] v, input logic rel);
        bus.force_req   = 1'b1;
        bus.force_mask  = m;
        bus.force_val   = v;
        bus.release_req = rel;
    endtask

    initial begin
        idle();
        bus0.en = 1'b0; bus0.R = '0; bus0.force_req = 1'b0;
        bus0.force_val = '0; bus0.force_mask = '0; bus0.release_req = 1'b0;

        do_reset();
        chk_on = 1'b1;
        check("reset_L", 8'(bus.L), 8'h00);
        check("reset_valid", 8'(bus.valid), 8'h0);
        check("reset_forced", 8'(bus.forced), 8'h0);

        // Basic latency and valid rise.
        bus.en = 1'b1; bus.R = 6'h15; step();
        check("lat_valid_1", 8'(bus.valid), 8'h0);
        bus.en = 1'b1; bus.R = 6'h2A; step();
        check("lat_L_15", 8'(bus.L), 8'h15);
        check("lat_valid_2", 8'(bus.valid), 8'h1);
        bus.en = 1'b1; bus.R = 6'h3F; step();
        check("lat_L_2A", 8'(bus.L), 8'h2A);
        bus.en = 1'b1; bus.R = 6'h00; step();
        check("lat_L_3F", 8'(bus.L), 8'h3F);

        // Hold with en low.
        do_reset();
        bus.en = 1'b1; bus.R = 6'h01; step();
        bus.en = 1'b0; bus.R = 6'h02; step();
        check("hold_L", 8'(bus.L), 8'h00);
        bus.en = 1'b1; bus.R = 6'h02; step();
        check("hold_L_01", 8'(bus.L), 8'h01);

        // Force overlay and accumulation.
        do_reset();
        bus.force_req = 1'b1; bus.force_mask = 6'h00; bus.force_val = 6'h3F; step();
        check("zero_mask_forced", 8'(bus.forced), 8'h0);
        check("zero_mask_L", 8'(bus.L), 8'h00);
        force_it(6'h0F, 6'h0A, 1'b0); step();
        check("force1_L", 8'(bus.L), 8'h0A);
        check("force1_forced", 8'(bus.forced), 8'h1);
        force_it(6'h30, 6'h30, 1'b0); step();
        check("force2_L", 8'(bus.L), 8'h3A);

        // Simultaneous force and release leaves only the new mask.
        force_it(6'h01, 6'h01, 1'b1); step();
        check("simul_L", 8'(bus.L), 8'h01);
        check("simul_forced", 8'(bus.forced), 8'h1);
        bus.release_req = 1'b1; step();
        check("release_L", 8'(bus.L), 8'h00);
        check("release_forced", 8'(bus.forced), 8'h0);

        // Reset mid-fill while forced.
        bus.en = 1'b1; bus.R = 6'h2A; step();
        force_it(6'h3F, 6'h15, 1'b0); bus.en = 1'b1; bus.R = 6'h2A; step();
        check("midrst_pre_L", 8'(bus.L), 8'h15);
        rst = 1'b1; bus.en = 1'b1; bus.R = 6'h3F; force_it(6'h3F, 6'h3F, 1'b0); step();
        check("midrst_L", 8'(bus.L), 8'h00);
        check("midrst_valid", 8'(bus.valid), 8'h0);
        check("midrst_forced", 8'(bus.forced), 8'h0);
        bus.en = 1'b1; bus.R = 6'h11; step();
        check("refill_valid_1", 8'(bus.valid), 8'h0);
        check("refill_L_1", 8'(bus.L), 8'h00);
        bus.en = 1'b1; bus.R = 6'h22; step();
        check("refill_valid_2", 8'(bus.valid), 8'h1);
        check("refill_L_2", 8'(bus.L), 8'h11);

        // Random traffic checked by the model every cycle.
        for (int i = 0; i < 2000; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            bus.en          = $urandom_range(0, 3) != 0;
            bus.R           = W'($urandom);
            bus.force_req   = ($urandom_range(0, 3) == 0);
            bus.force_mask  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            bus.force_val   = W'($urandom);
            bus.release_req = ($urandom_range(0, 5) == 0);
            @(posedge clk);
            #1;
        end
        idle();
        step();

        // STAGES=0, FORCE_EN=0: combinational pass-through, forces ignored.
        for (int i = 0; i < 40; i++) begin
            bus0.en          = $urandom_range(0, 1);
            bus0.R           = W'($urandom);
            bus0.force_req   = $urandom_range(0, 1);
            bus0.force_mask  = W'($urandom);
            bus0.force_val   = W'($urandom);
            bus0.release_req = $urandom_range(0, 1);
            #1;
            check("s0_L", 8'(bus0.L), 8'(bus0.R));
            check("s0_valid", 8'(bus0.valid), 8'h1);
            check("s0_forced", 8'(bus0.forced), 8'h0);
            @(posedge clk);
            #1;
            check("s0_L_post", 8'(bus0.L), 8'(bus0.R));
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ixc_assign_pipe.md
IXC_ASSIGN_PIPE -- requirements
Module: ixc_assign_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, the bit width of R and L.
REQ-002 The block SHALL have parameter STAGES, default 2, legal range 0..8, the register stages from R to L.
REQ-003 The block SHALL have parameter FORCE_EN, default 1; when 0 the force logic is removed and force inputs are ignored.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 The block SHALL have port en, input, 1, pipeline advance enable.
REQ-007 The block SHALL have port R, input, WIDTH, source value.
REQ-008 The block SHALL have port force_req, input, 1, single-cycle force load pulse.
REQ-009 The block SHALL have port force_val, input, WIDTH, value for forced bits.
REQ-010 The block SHALL have port force_mask, input, WIDTH, bits to force (1 = forced).
REQ-011 The block SHALL have port release_req, input, 1, single-cycle release of all forced bits.
REQ-012 The block SHALL have port L, output, WIDTH, destination value.
REQ-013 The block SHALL have port valid, output, 1, pipeline holds STAGES accepted samples since reset.
REQ-014 The block SHALL have port forced, output, 1, high while any bit of L is forced.

Function
REQ-015 Pipeline: on each edge with en=1, stage 0 captures R and stage k captures stage k-1; with en=0 all stages hold.
REQ-016 Latency: a sample of R accepted with en=1 SHALL appear on the unforced bits of L exactly STAGES enabled edges later.
REQ-017 STAGES=0: L SHALL equal R combinationally on unforced bits, and valid SHALL be constantly 1.
REQ-018 Fill counter: increments on each enabled edge, saturates at STAGES; valid=1 iff count==STAGES.
REQ-019 Force state machine: two states, FREE (mask register zero) and FORCED (mask register nonzero); forced=1 iff FORCED.
REQ-020 FREE->FORCED: force_req=1 with nonzero force_mask; mask register becomes force_mask and value register becomes force_val.
REQ-021 FORCED + force_req: mask register becomes old_mask OR force_mask; value register bits under force_mask are updated from force_val, all other bits hold.
REQ-022 FORCED->FREE: release_req=1 without force_req; mask register cleared.
REQ-023 Simultaneous force_req and release_req: release applies first, so the mask register becomes exactly force_mask; FREE if force_mask is zero.
REQ-024 force_req with zero force_mask SHALL leave the state and registers unchanged.
REQ-025 Output: L[i] = value_reg[i] when mask_reg[i]=1, else pipeline output bit i; force takes effect on the edge after force_req (registered), release likewise.
REQ-026 Forcing SHALL NOT stall or alter pipeline contents; after release, L shows the current pipeline output with no bubble.
REQ-027 en has no effect on force/release handling.

Reset
REQ-028 rst=1 at an edge SHALL clear all pipeline stages, fill count, mask register and value register; it overrides en, force_req and release_req in the same cycle.
REQ-029 After reset, L=0 (STAGES>0), valid=0 (STAGES>0), forced=0; the state is FREE.
REQ-030 Reset mid-fill or mid-force SHALL discard all in-flight samples and forces, with no partial retention.

Structure
REQ-031 Package ixc_assign_pkg SHALL hold MAX_STAGES=8, the force-state enum {FREE, FORCED}, and a STAGES legality check function.
REQ-032 One register stage (WIDTH flops with enable and sync reset) SHALL be the sub-module ixc_assign_stage, instantiated STAGES times by generate.
REQ-033 An illegal STAGES SHALL produce an elaboration error.

Verification
REQ-034 WIDTH=6, STAGES=2: reset, then en=1 with R=0x15, 0x2A, 0x3F on consecutive cycles -> L=0x15, 0x2A, 0x3F on cycles 2, 3, 4 after the first; valid rises on the 2nd enabled edge.
REQ-035 en toggling 1,0,1 with R=0x01, 0x02 (en=0 on the middle cycle) -> the held sample is not lost, and L reaches 0x01 after two enabled edges.
REQ-036 Pipeline output 0x00, force_req with mask=0x0F and val=0x0A -> L=0x0A and forced=1; then force_req with mask=0x30 and val=0x30 -> L=0x3A.
REQ-037 force_req and release_req in the same cycle, mask=0x01, val=0x01, previous mask=0x3F -> only bit 0 remains forced.
REQ-038 rst asserted mid-fill while forced -> next cycle L=0, valid=0, forced=0; a new fill takes the full STAGES cycles.
REQ-039 STAGES=0 and FORCE_EN=0: L tracks R in the same cycle for random R, and force inputs have no effect.
